// File: rtl/time_counters.sv
// Packed-BCD hours/minutes/seconds datapath with internal 1 s and set-mode
// increment prescalers, controlled by the clock FSM's reset/mode/enable lines.
module time_counters #(
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned INC_DIV  = 6000000
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  output logic [7:0] o_Hours,
  output logic [7:0] o_Minutes,
  output logic [7:0] o_Seconds,
  output logic       o_Second_Pulse
);

  localparam int unsigned SW = $clog2(TICK_DIV);
  localparam int unsigned IW = $clog2(INC_DIV);
  localparam logic [SW-1:0] SP_MAX = SW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IP_MAX = IW'(INC_DIV - 1);

  logic [SW-1:0] sp;
  logic [IW-1:0] ip;
  logic          sp_adv;
  logic          tick_s;
  logic          tick_i;
  logic [7:0]    sec_n;
  logic [7:0]    min_n;
  logic [7:0]    hr_n;
  logic          pulse_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign sp_adv = !i_Counters_Enable_Increment && i_Counters_Enable_Count[0];
  assign tick_s = sp_adv && (sp == SP_MAX);
  assign tick_i = i_Counters_Enable_Increment && (ip == IP_MAX);

  // Run mode ripples carries through enabled units; set mode bumps each
  // enabled unit on its own. Counters_Reset overrides seconds last.
  always_comb begin
    sec_n   = o_Seconds;
    min_n   = o_Minutes;
    hr_n    = o_Hours;
    pulse_n = 1'b0;
    if (!i_Counters_Enable_Increment) begin
      if (tick_s && !i_Counters_Reset) begin
        sec_n   = bcd_inc(o_Seconds, 8'h59);
        pulse_n = 1'b1;
        if (o_Seconds == 8'h59 && i_Counters_Enable_Count[1]) begin
          min_n = bcd_inc(o_Minutes, 8'h59);
          if (o_Minutes == 8'h59 && i_Counters_Enable_Count[2])
            hr_n = bcd_inc(o_Hours, 8'h23);
        end
      end
    end else if (tick_i) begin
      if (i_Counters_Enable_Count[0]) sec_n = bcd_inc(o_Seconds, 8'h59);
      if (i_Counters_Enable_Count[1]) min_n = bcd_inc(o_Minutes, 8'h59);
      if (i_Counters_Enable_Count[2]) hr_n  = bcd_inc(o_Hours, 8'h23);
    end
    if (i_Counters_Reset) sec_n = 8'h00;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sp             <= '0;
      ip             <= '0;
      o_Hours        <= '0;
      o_Minutes      <= '0;
      o_Seconds      <= '0;
      o_Second_Pulse <= 1'b0;
    end else begin
      if (i_Counters_Reset)
        sp <= '0;
      else if (sp_adv)
        sp <= tick_s ? '0 : sp + 1'b1;

      if (!i_Counters_Enable_Increment)
        ip <= '0;
      else
        ip <= tick_i ? '0 : ip + 1'b1;

      o_Hours        <= hr_n;
      o_Minutes      <= min_n;
      o_Seconds      <= sec_n;
      o_Second_Pulse <= pulse_n;
    end
  end

endmodule

// File: tb/tb_time_counters.sv
// Directed bench for time_counters with TICK_DIV=4, INC_DIV=2: a table of
// {cycles, inputs, expected time} records plus hand sequences for hold and async reset.
module tb_time_counters;

  logic       clk;
  logic       rst_n;
  logic       creset;
  logic       mode;
  logic [2:0] en;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       pulse;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  time_counters #(
    .TICK_DIV(4),
    .INC_DIV (2)
  ) dut (
    .i_Clock                     (clk),
    .i_Reset_n                   (rst_n),
    .i_Counters_Reset            (creset),
    .i_Counters_Enable_Increment (mode),
    .i_Counters_Enable_Count     (en),
    .o_Hours                     (hours),
    .o_Minutes                   (minutes),
    .o_Seconds                   (seconds),
    .o_Second_Pulse              (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       c;
    logic       m;
    logic [2:0] e;
    logic [7:0] h;
    logic [7:0] mi;
    logic [7:0] s;
    logic       p;
  } vec_t;

  vec_t tbl[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eh, input logic [7:0] em,
                       input logic [7:0] es, input logic ep);
    n_cmp++;
    if ({hours, minutes, seconds, pulse} !== {eh, em, es, ep}) begin
      n_bad++;
      $display("FAIL %s: got %h:%h:%h pulse=%b, want %h:%h:%h pulse=%b",
               name, hours, minutes, seconds, pulse, eh, em, es, ep);
    end
  endtask

  initial begin
    // n, creset, mode, en, expected H, M, S, pulse after the n-th edge
    tbl.push_back('{3,   1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h01, 1'b1});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h01, 1'b0});
    tbl.push_back('{116, 1'b0, 1'b1, 3'b001, 8'h00, 8'h00, 8'h59, 1'b0});
    tbl.push_back('{2,   1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h59, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b111, 8'h00, 8'h01, 8'h00, 1'b1});
    tbl.push_back('{16,  1'b0, 1'b1, 3'b011, 8'h00, 8'h09, 8'h08, 1'b0});
    tbl.push_back('{102, 1'b0, 1'b1, 3'b001, 8'h00, 8'h09, 8'h59, 1'b0});
    tbl.push_back('{3,   1'b0, 1'b0, 3'b111, 8'h00, 8'h09, 8'h59, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b111, 8'h00, 8'h10, 8'h00, 1'b1});
    tbl.push_back('{46,  1'b0, 1'b1, 3'b111, 8'h23, 8'h33, 8'h23, 1'b0});
    tbl.push_back('{52,  1'b0, 1'b1, 3'b011, 8'h23, 8'h59, 8'h49, 1'b0});
    tbl.push_back('{20,  1'b0, 1'b1, 3'b001, 8'h23, 8'h59, 8'h59, 1'b0});
    tbl.push_back('{3,   1'b0, 1'b0, 3'b111, 8'h23, 8'h59, 8'h59, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 8'h00, 1'b1});
    tbl.push_back('{10,  1'b0, 1'b1, 3'b110, 8'h05, 8'h05, 8'h00, 1'b0});
    tbl.push_back('{106, 1'b0, 1'b1, 3'b010, 8'h05, 8'h58, 8'h00, 1'b0});
    tbl.push_back('{150, 1'b0, 1'b0, 3'b111, 8'h05, 8'h58, 8'h37, 1'b0});
    tbl.push_back('{3,   1'b1, 1'b0, 3'b000, 8'h05, 8'h58, 8'h00, 1'b0});
    tbl.push_back('{3,   1'b0, 1'b0, 3'b111, 8'h05, 8'h58, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b111, 8'h05, 8'h58, 8'h01, 1'b1});
    tbl.push_back('{3,   1'b0, 1'b0, 3'b111, 8'h05, 8'h58, 8'h01, 1'b0});
    tbl.push_back('{1,   1'b1, 1'b0, 3'b111, 8'h05, 8'h58, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b1, 3'b010, 8'h05, 8'h58, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b1, 3'b010, 8'h05, 8'h59, 8'h00, 1'b0});
    tbl.push_back('{2,   1'b0, 1'b1, 3'b010, 8'h05, 8'h00, 8'h00, 1'b0});
    tbl.push_back('{2,   1'b0, 1'b1, 3'b010, 8'h05, 8'h01, 8'h00, 1'b0});
    tbl.push_back('{2,   1'b0, 1'b1, 3'b011, 8'h05, 8'h02, 8'h01, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b1, 3'b011, 8'h05, 8'h02, 8'h01, 1'b0});
    tbl.push_back('{1,   1'b1, 1'b1, 3'b011, 8'h05, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{34,  1'b0, 1'b1, 3'b100, 8'h22, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{2,   1'b0, 1'b1, 3'b100, 8'h23, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{2,   1'b0, 1'b1, 3'b100, 8'h00, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b1, 3'b100, 8'h00, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b100, 8'h00, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b1, 3'b100, 8'h00, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b1, 3'b100, 8'h01, 8'h03, 8'h00, 1'b0});
    tbl.push_back('{118, 1'b0, 1'b1, 3'b001, 8'h01, 8'h03, 8'h59, 1'b0});
    tbl.push_back('{3,   1'b0, 1'b0, 3'b001, 8'h01, 8'h03, 8'h59, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b001, 8'h01, 8'h03, 8'h00, 1'b1});
    tbl.push_back('{112, 1'b0, 1'b1, 3'b011, 8'h01, 8'h59, 8'h56, 1'b0});
    tbl.push_back('{6,   1'b0, 1'b1, 3'b001, 8'h01, 8'h59, 8'h59, 1'b0});
    tbl.push_back('{3,   1'b0, 1'b0, 3'b011, 8'h01, 8'h59, 8'h59, 1'b0});
    tbl.push_back('{1,   1'b0, 1'b0, 3'b011, 8'h01, 8'h00, 8'h00, 1'b1});

    rst_n  = 1'b0;
    creset = 1'b0;
    mode   = 1'b0;
    en     = 3'b000;
    #12;
    check("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      creset = tbl[i].c;
      mode   = tbl[i].m;
      en     = tbl[i].e;
      for (int k = 0; k < tbl[i].n; k++) cyc();
      check($sformatf("vec%0d", i), tbl[i].h, tbl[i].mi, tbl[i].s, tbl[i].p);
    end

    // Prescaler must hold mid-count while run mode has seconds disabled.
    creset = 1'b0; mode = 1'b0; en = 3'b111;
    cyc(); cyc();
    check("pre_hold", 8'h01, 8'h00, 8'h00, 1'b0);
    en = 3'b000;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check($sformatf("hold%0d", k), 8'h01, 8'h00, 8'h00, 1'b0);
    end
    en = 3'b111;
    cyc();
    check("resume_a", 8'h01, 8'h00, 8'h00, 1'b0);
    cyc();
    check("resume_b", 8'h01, 8'h00, 8'h01, 1'b1);

    // Async reset mid-cycle while the pulse is high.
    #3 rst_n = 1'b0;
    #1;
    check("async_clear", 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(); cyc();
    check("async_held", 8'h00, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("post_rel%0d", k), 8'h00, 8'h00,
            (k >= 4) ? 8'h01 : 8'h00, (k == 4) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_counters.md
Name: time_counters

Overview:
- Time-keeping datapath driven by the clock control FSM: holds hours, minutes and seconds as packed BCD.
- Generates its own 1 s tick and set-mode auto-increment tick from the system clock.
- Obeys the FSM's counter reset, increment-mode and per-unit count-enable signals.
- Feeds the display driver with BCD time and a once-per-second strobe.

Parameters:
- TICK_DIV, 12000000, clock cycles per second tick (min 2).
- INC_DIV, 6000000, clock cycles per set-mode increment (min 2).

Ports:
- i_Clock  in  1  system clock, all state on rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_Counters_Reset  in  1  synchronous clear of seconds and second prescaler
- i_Counters_Enable_Increment  in  1  0 = run mode, 1 = set mode
- i_Counters_Enable_Count  in  3  per-unit enable {hours, minutes, seconds}
- o_Hours  out  8  BCD 00..23, [7:4] tens, [3:0] units
- o_Minutes  out  8  BCD 00..59
- o_Seconds  out  8  BCD 00..59
- o_Second_Pulse  out  1  one-cycle strobe, high in the first cycle a run-mode seconds increment is visible

Behaviour:
- Async reset (i_Reset_n=0): all outputs 0x00 / 0, both prescalers 0. Release takes effect on the next rising edge.
- All outputs registered; no combinational path from inputs to outputs.
- Second prescaler sp, 0..TICK_DIV-1:
  - Advances only when Enable_Increment=0 and Enable_Count[0]=1; otherwise holds.
  - tick_s = (sp==TICK_DIV-1 and advancing); that edge wraps sp to 0.
- Increment prescaler ip, 0..INC_DIV-1:
  - Advances only when Enable_Increment=1; cleared to 0 on any cycle with Enable_Increment=0.
  - tick_i = (ip==INC_DIV-1 and advancing); wraps to 0.
  - The first set-mode increment lands INC_DIV cycles after entering set mode.
- Run mode (Enable_Increment=0), on tick_s:
  - Seconds +1; 59 wraps to 00 and generates a carry.
  - Carry increments minutes only if Enable_Count[1]=1.
  - Minute wrap 59->00 generates a carry into hours only if Enable_Count[2]=1.
  - Hours 23->00 wraps without carry.
  - A disabled unit holds its value and breaks the carry chain.
  - o_Second_Pulse = 1 on the cycle after tick_s (registered with the new value).
- Set mode (Enable_Increment=1), on tick_i:
  - Each enabled unit increments independently: seconds 59->00, minutes 59->00, hours 23->00.
  - No carries between units in set mode.
  - o_Second_Pulse stays 0.
- BCD arithmetic: units digit 9->0 with tens+1.
  - Wrap detection on the full value: seconds/minutes at 0x59, hours at 0x23.
  - Non-BCD values are unreachable.
- i_Counters_Reset=1:
  - On each such edge: seconds <= 0x00, sp <= 0.
  - Takes priority over any simultaneous tick; a suppressed tick produces no carry and no pulse.
  - Minutes and hours unaffected.
  - Holding it for multiple cycles keeps seconds at 00.
- Simultaneous Counters_Reset and set-mode tick_i: seconds cleared; enabled minutes/hours still increment.
- Mode switch mid-count:
  - Leaving run mode freezes sp at its current value; it resumes from there when run mode returns, unless Counters_Reset clears it.
  - Entering set mode restarts ip from 0.
- Async reset asserted mid-operation: immediate clear regardless of mode or tick.

Test Plan:
- Reset value: TICK_DIV=4, INC_DIV=2; assert i_Reset_n=0 mid-count -> outputs 0x00/0x00/0x00 immediately, pulse 0. Release with enables 111, mode 0 -> seconds=0x01 visible 4 cycles after release, pulse high for exactly that cycle.
- Run-mode carry chain: preset via set mode to 23:59, then run; seconds reach 0x59 -> next tick gives 0x00:0x00:0x00. Also check 00:00:59 -> 00:01:00 and 00:09:59 -> 00:10:00.
- Seconds reset mid-count: run to seconds=0x37, assert Counters_Reset 3 cycles (enables 000) -> seconds=0x00, minutes/hours unchanged. After release with enables 111, next increment comes a full 4 cycles later.
- Set minutes: mode 1, enable 010, minutes=0x58, hours=0x05 -> increments every 2 cycles: 0x59, 0x00, 0x01. Hours stay 0x05, seconds frozen, no pulse.
- Set hours: mode 1, enable 100, hours=0x22 -> 0x23, 0x00. Minutes unchanged. Dropping mode to 0 for one cycle then back delays the next increment by a full 2 cycles.
- Carry gating: run mode, enables 001, seconds 0x59 -> 0x00 with minutes unchanged. Enables 000 -> sp holds and no change over 20 cycles.
